// File: rtl/branch_pc_pkg.sv
// Shared types and constants for the fetch-side branch/PC stage.
package branch_pc_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OFF_W = 12;
  localparam int unsigned CNT_W = 3;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } pc_state_e;

  typedef struct packed {
    logic [XLEN-1:0] target;
    logic            misalign;
  } target_t;

endpackage

// File: rtl/branch_target_calc.sv
// Control-transfer target selection (jal > jalr > branch) and misalign detection.
module branch_target_calc
  import branch_pc_pkg::*;
(
  input  logic             jal,
  input  logic             jalr,
  input  logic [OFF_W-1:0] branoff,
  input  logic [XLEN-1:0]  pc_id,
  output target_t          tgt_c
);

  logic [XLEN-1:0] off_sext;
  logic [XLEN-1:0] target;

  always_comb begin
    off_sext = {{(XLEN-OFF_W){branoff[OFF_W-1]}}, branoff};
    // jalr offset is already rs1+imm; only bit 0 is cleared
    if (jalr && !jal) begin
      target = {{(XLEN-OFF_W){1'b0}}, branoff[OFF_W-1:1], 1'b0};
    end else begin
      target = pc_id + off_sext;
    end
    tgt_c.target   = target;
    tgt_c.misalign = target[1];
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC register with redirect, stall-deferred redirect (HOLD) and flush window.
module branch_pc_unit
  import branch_pc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic             jal,
  input  logic             jalr,
  input  logic [OFF_W-1:0] branoff,
  input  logic [XLEN-1:0]  pc_id,
  output logic [XLEN-1:0]  pc_if,
  output logic             redirect,
  output logic             flush,
  output logic [XLEN-1:0]  link_addr,
  output logic             misalign
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  pc_state_e       state_q, state_nxt;
  logic [XLEN-1:0] pending_q, pending_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [XLEN-1:0] pc_nxt, link_nxt;
  logic            redirect_nxt, flush_nxt, misalign_nxt;

  logic            req_c;
  logic [XLEN-1:0] pc_seq_c;
  logic [XLEN-1:0] link_c;
  target_t         tgt_c;

  assign req_c    = br_valid & (jal | jalr | br_taken);
  assign pc_seq_c = pc_if + PC_STEP;
  assign link_c   = pc_id + PC_STEP;

  branch_target_calc u_target (
    .jal     (jal),
    .jalr    (jalr),
    .branoff (branoff),
    .pc_id   (pc_id),
    .tgt_c   (tgt_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_nxt    = state_q;
    pending_nxt  = pending_q;
    cnt_nxt      = cnt_q;
    pc_nxt       = pc_if;
    link_nxt     = link_addr;
    redirect_nxt = 1'b0;
    flush_nxt    = 1'b0;
    misalign_nxt = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          pc_nxt = pc_seq_c;
        end
        if (req_c) begin
          if (tgt_c.misalign) begin
            misalign_nxt = 1'b1;
          end else begin
            if (jal || jalr) begin
              link_nxt = link_c;
            end
            flush_nxt = 1'b1;
            if (stall) begin
              pending_nxt = tgt_c.target;
              state_nxt   = ST_HOLD;
            end else begin
              pc_nxt       = tgt_c.target;
              redirect_nxt = 1'b1;
              cnt_nxt      = FLUSH_LOAD;
              state_nxt    = ST_FLUSH;
            end
          end
        end
      end

      ST_HOLD: begin
        flush_nxt = 1'b1;
        if (!stall) begin
          pc_nxt       = pending_q;
          redirect_nxt = 1'b1;
          cnt_nxt      = FLUSH_LOAD;
          state_nxt    = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        flush_nxt = 1'b1;
        if (!stall) begin
          pc_nxt  = pc_seq_c;
          cnt_nxt = cnt_q - CNT_W'(1);
          // last flush cycle: drop flush together with the return to RUN
          if (cnt_q == CNT_W'(1)) begin
            flush_nxt = 1'b0;
            state_nxt = ST_RUN;
          end
        end
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pending_q <= '0;
      cnt_q     <= '0;
      pc_if     <= RESET_PC;
      link_addr <= '0;
      redirect  <= 1'b0;
      flush     <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      pending_q <= pending_nxt;
      cnt_q     <= cnt_nxt;
      pc_if     <= pc_nxt;
      link_addr <= link_nxt;
      redirect  <= redirect_nxt;
      flush     <= flush_nxt;
      misalign  <= misalign_nxt;
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: driver queues hand-computed expectations, monitor checks.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic        jal;
  logic        jalr;
  logic [11:0] branoff;
  logic [31:0] pc_id;
  logic [31:0] pc_if;
  logic        redirect;
  logic        flush;
  logic [31:0] link_addr;
  logic        misalign;

  typedef struct {
    logic [31:0] pc;
    logic        red;
    logic        fl;
    logic [31:0] link;
    logic        mis;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  branch_pc_unit #(
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_taken  (br_taken),
    .jal       (jal),
    .jalr      (jalr),
    .branoff   (branoff),
    .pc_id     (pc_id),
    .pc_if     (pc_if),
    .redirect  (redirect),
    .flush     (flush),
    .link_addr (link_addr),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the outputs expected after the next rise
  task automatic cyc(input logic rst, input logic st, input logic bv, input logic bt,
                     input logic j, input logic jr, input logic [11:0] off, input logic [31:0] pcid,
                     input logic [31:0] epc, input logic ered, input logic efl,
                     input logic [31:0] elink, input logic emis, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    stall    = st;
    br_valid = bv;
    br_taken = bt;
    jal      = j;
    jalr     = jr;
    branoff  = off;
    pc_id    = pcid;
    e.pc = epc; e.red = ered; e.fl = efl; e.link = elink; e.mis = emis; e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are registered, so compare one step after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({e.name, ".pc_if"},     pc_if,          e.pc);
        chk({e.name, ".redirect"},  32'(redirect),  32'(e.red));
        chk({e.name, ".flush"},     32'(flush),     32'(e.fl));
        chk({e.name, ".link_addr"}, link_addr,      e.link);
        chk({e.name, ".misalign"},  32'(misalign),  32'(e.mis));
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    jal = 1'b0; jalr = 1'b0; branoff = '0; pc_id = '0;

    //  rst st bv bt jal jalr off     pc_id          pc_if          red fl link           mis
    cyc(0, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0000, 0, 0, 32'h0,         0, "reset");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0004, 0, 0, 32'h0,         0, "seq4");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0008, 0, 0, 32'h0,         0, "seq8");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_000C, 0, 0, 32'h0,         0, "seq12");
    // taken branch backwards, jal pulses inside the flush window must be dropped
    cyc(1, 0, 1, 1, 0, 0, 12'hFF0, 32'h100,       32'h0000_00F0, 1, 1, 32'h0,         0, "br_redir");
    cyc(1, 0, 1, 1, 1, 0, 12'h020, 32'h300,       32'h0000_00F4, 0, 1, 32'h0,         0, "flush1_ign");
    cyc(1, 0, 1, 1, 1, 0, 12'h020, 32'h300,       32'h0000_00F8, 0, 0, 32'h0,         0, "flush_end");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_00FC, 0, 0, 32'h0,         0, "run_again");
    // jal under a 3-cycle stall
    cyc(1, 1, 1, 0, 1, 0, 12'h020, 32'h200,       32'h0000_00FC, 0, 1, 32'h204,       0, "hold_enter");
    cyc(1, 1, 1, 1, 0, 0, 12'h010, 32'h500,       32'h0000_00FC, 0, 1, 32'h204,       0, "hold_ign");
    cyc(1, 1, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_00FC, 0, 1, 32'h204,       0, "hold3");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0220, 1, 1, 32'h204,       0, "hold_rel");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0224, 0, 1, 32'h204,       0, "hold_fl1");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0228, 0, 0, 32'h204,       0, "hold_fl_end");
    // jalr misaligned, then aligned with bit 0 forced low; stall inside flush
    cyc(1, 0, 1, 0, 0, 1, 12'h00A, 32'h400,       32'h0000_022C, 0, 0, 32'h204,       1, "jalr_mis");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0230, 0, 0, 32'h204,       0, "mis_clear");
    cyc(1, 0, 1, 0, 0, 1, 12'h009, 32'h400,       32'h0000_0008, 1, 1, 32'h404,       0, "jalr_ok");
    cyc(1, 1, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0008, 0, 1, 32'h404,       0, "flush_stall");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_000C, 0, 1, 32'h404,       0, "flush_str1");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0010, 0, 0, 32'h404,       0, "flush_str_end");
    // jal and jalr together: jal target wins
    cyc(1, 0, 1, 0, 1, 1, 12'h010, 32'h600,       32'h0000_0610, 1, 1, 32'h604,       0, "jal_prio");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0614, 0, 1, 32'h604,       0, "prio_fl1");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0618, 0, 0, 32'h604,       0, "prio_end");
    // negative offset wrap to top of space, then sequential wrap to zero
    cyc(1, 0, 1, 1, 0, 0, 12'hFF8, 32'h4,         32'hFFFF_FFFC, 1, 1, 32'h604,       0, "br_wrap");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0000, 0, 1, 32'h604,       0, "pc_wrap");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0004, 0, 0, 32'h604,       0, "wrap_end");
    cyc(1, 0, 1, 0, 0, 0, 12'h0F0, 32'h100,       32'h0000_0008, 0, 0, 32'h604,       0, "not_taken");
    cyc(1, 0, 1, 1, 0, 0, 12'h002, 32'h100,       32'h0000_000C, 0, 0, 32'h604,       1, "br_mis");
    // reset while holding a pending target
    cyc(1, 1, 1, 1, 0, 0, 12'h040, 32'h100,       32'h0000_000C, 0, 1, 32'h604,       0, "hold2_enter");
    cyc(0, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0000, 0, 0, 32'h0,         0, "rst_hold");
    #1;
    chk("rst_hold_async.pc_if", pc_if, 32'h0);
    chk("rst_hold_async.flush", 32'(flush), 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0004, 0, 0, 32'h0,         0, "post_rst1");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0008, 0, 0, 32'h0,         0, "post_rst2");
    // reset inside the flush window
    cyc(1, 0, 1, 1, 0, 0, 12'h020, 32'h100,       32'h0000_0120, 1, 1, 32'h0,         0, "br_pre_rst");
    cyc(0, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0000, 0, 0, 32'h0,         0, "rst_flush");
    #1;
    chk("rst_flush_async.pc_if", pc_if, 32'h0);
    chk("rst_flush_async.flush", 32'(flush), 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0004, 0, 0, 32'h0,         0, "post_rst3");
    cyc(1, 0, 0, 0, 0, 0, 12'h000, 32'h0,         32'h0000_0008, 0, 0, 32'h0,         0, "post_rst4");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
